avalon_sample_sink: RTL and testbench

//  Avalon-MM slave that terminates the FFT result stream written by the Avalon master.

---
 rtl/avalon_pkg.sv | 21 ++
 rtl/sample_buffer.sv | 32 +++
 rtl/avalon_sample_sink.sv | 125 ++++++++++++
 tb/tb_avalon_sample_sink.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// Shared Avalon types and constants for the FFT result path.
// The stream address is common to the master and the sample sink.
package avalon_pkg;

   localparam logic [63:0] STREAM_ADDR = 64'h0000_0000_FFFF_FFFF;
   localparam int          DATA_W      = 16;

   typedef enum logic [1:0] {
      OKAY      = 2'b00,
      SLVERR    = 2'b10,
      DECODEERR = 2'b11
   } avalon_resp_t;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      FULL,
      ERR
   } sink_state_t;

endpackage

// File: rtl/sample_buffer.sv
// Sample storage: one write port, one registered read port.
// The storage array is never reset; only the read register clears.
module sample_buffer #(
   parameter int NUM_SAMPLES = 512,
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [NUM_SAMPLES];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_sample_sink.sv
// Avalon-MM slave terminating the FFT result stream: edge-detected sample
// capture, frame FSM, per-write response codes and a status/consumer read path.
module avalon_sample_sink #(
   parameter int          NUM_SAMPLES = 512,
   parameter int          ADDR_W      = 9,
   parameter logic [63:0] STREAM_ADDR = avalon_pkg::STREAM_ADDR
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              write,
   input  logic              read,
   input  logic [63:0]       address,
   input  logic [15:0]       writedata,
   output logic [15:0]       readdata,
   output logic [1:0]        response,
   output logic              result_ready,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [15:0]       rd_data,
   input  logic              result_ack
);
   import avalon_pkg::*;

   localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(NUM_SAMPLES);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
   // Status word is zero-padded above {frame_full, cnt}.
   localparam int              PAD_W    = 16 - ADDR_W - 2;

   sink_state_t     state_q, state_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   avalon_resp_t    resp_q, resp_d, edge_resp;
   logic            write_q;
   logic [15:0]     readdata_q;
   logic            wr_edge, addr_hit, full, store;

   assign wr_edge      = write & ~write_q;
   assign addr_hit     = (address == STREAM_ADDR);
   assign full         = (cnt_q == CNT_FULL);
   assign result_ready = (state_q == FULL) || ((state_q == ERR) && full);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      store     = 1'b0;
      edge_resp = OKAY;
      case (state_q)
         IDLE, RECV: begin
            if (wr_edge) begin
               if (!addr_hit) begin
                  edge_resp = DECODEERR;
               end else if (full) begin
                  edge_resp = SLVERR;
                  state_d   = ERR;
               end else begin
                  store   = 1'b1;
                  cnt_d   = cnt_q + CNT_ONE;
                  state_d = RECV;
               end
            end else if (full) begin
               state_d = FULL;
            end
         end
         FULL: begin
            // A same-cycle acknowledge re-arms the sink and rejects the write.
            if (result_ack) begin
               cnt_d     = '0;
               state_d   = IDLE;
               edge_resp = SLVERR;
            end else if (wr_edge) begin
               edge_resp = addr_hit ? SLVERR : DECODEERR;
               if (addr_hit) state_d = ERR;
            end
         end
         ERR: begin
            edge_resp = SLVERR;
            if (!write) state_d = full ? FULL : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign resp_d = wr_edge ? edge_resp : resp_q;

   // Error codes must reach the master in the edge cycle, so bypass the register there.
   always_comb begin
      response = OKAY;
      if (write && read)  response = SLVERR;
      else if (wr_edge)   response = edge_resp;
      else if (write)     response = resp_q;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         resp_q     <= OKAY;
         write_q    <= 1'b0;
         readdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         write_q <= write;
         if (read && !write) readdata_q <= {{PAD_W{1'b0}}, result_ready, cnt_q};
      end
   end

   assign readdata = readdata_q;

   sample_buffer #(
      .NUM_SAMPLES (NUM_SAMPLES),
      .ADDR_W      (ADDR_W),
      .DATA_W      (16)
   ) u_buf (
      .clk     (clk),
      .n_rst   (n_rst),
      .we_i    (store),
      .waddr_i (cnt_q[ADDR_W-1:0]),
      .wdata_i (writedata),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

endmodule

// File: tb/tb_avalon_sample_sink.sv
// Self-checking bench for avalon_sample_sink: directed frame sequence with random
// data/addresses/pulse widths, checked against a frame-level model.
module tb_avalon_sample_sink;

   localparam int          N     = 512;
   localparam int          AW    = 9;
   localparam logic [63:0] SADDR = 64'h0000_0000_FFFF_FFFF;

   logic          clk = 1'b0, n_rst = 1'b1;
   logic          write = 1'b0, read = 1'b0, rd_en = 1'b0, result_ack = 1'b0;
   logic [63:0]   address = '0;
   logic [15:0]   writedata = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [15:0]   readdata, rd_data;
   logic [1:0]    response;
   logic          result_ready;

   int n_checks = 0, n_pass = 0;

   // Model: stored samples and how many the current frame holds.
   logic [15:0] mdl_buf [N];
   int          mdl_cnt = 0;

   always #5 clk = ~clk;

   avalon_sample_sink dut (
      .clk(clk), .n_rst(n_rst), .write(write), .read(read), .address(address),
      .writedata(writedata), .readdata(readdata), .response(response),
      .result_ready(result_ready), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .result_ack(result_ack)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Response the specification demands for one accepted write edge; updates the model.
   function automatic logic [1:0] mdl_write(input logic [63:0] a, input logic [15:0] d, input bit ack);
      if (ack && mdl_cnt == N) begin
         mdl_cnt = 0;
         return 2'b10;
      end
      if (a != SADDR) return 2'b11;
      if (mdl_cnt == N) return 2'b10;
      mdl_buf[mdl_cnt] = d;
      mdl_cnt++;
      return 2'b00;
   endfunction

   task automatic wr(input logic [63:0] a, input logic [15:0] d, input int hold,
                     input bit ack, input bit rd);
      logic [1:0] exp_w;
      @(negedge clk);
      write = 1'b1; address = a; writedata = d; result_ack = ack; read = rd;
      exp_w = mdl_write(a, d, ack);
      #1 check("resp_edge", response, rd ? 2'b10 : exp_w);
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         result_ack = 1'b0; read = 1'b0;
         #1 check("resp_hold", response, exp_w);
      end
      @(negedge clk);
      write = 1'b0; result_ack = 1'b0; read = 1'b0;
      #1 check("resp_low", response, 2'b00);
   endtask

   task automatic status(input string tag);
      logic full;
      full = (mdl_cnt == N);
      @(negedge clk);
      read = 1'b1;
      #1 check({tag, "_rresp"}, response, 2'b00);
      check({tag, "_ready"}, result_ready, full);
      @(negedge clk);
      read = 1'b0;
      #1 check({tag, "_status"}, readdata, {5'b0, full, 10'(mdl_cnt)});
   endtask

   task automatic rdchk(input int idx);
      @(negedge clk);
      rd_en = 1'b1; rd_addr = AW'(idx);
      @(negedge clk);
      rd_en = 1'b0;
      #1 check("rd_data", rd_data, mdl_buf[idx]);
   endtask

   function automatic logic [63:0] bad_addr();
      logic [63:0] a;
      a = {$urandom, $urandom};
      if (a == SADDR) a = a ^ 64'h1;
      return a;
   endfunction

   initial begin
      #2 n_rst = 1'b0;
      repeat (2) @(negedge clk);
      #1 check("rst_readdata", readdata, 16'h0);
      check("rst_response", response, 2'b00);
      check("rst_ready", result_ready, 1'b0);
      check("rst_rd_data", rd_data, 16'h0);
      @(negedge clk) n_rst = 1'b1;
      status("rst");

      // Frame 1: data = i*3, 4-cycle pulses.
      for (int i = 0; i < N; i++) wr(SADDR, 16'(i * 3), 4, 1'b0, 1'b0);
      status("frame1");
      rdchk(5);
      rdchk(511);

      // Write while full is rejected and stores nothing.
      wr(SADDR, 16'hBEEF, 4, 1'b0, 1'b0);
      status("full_err");
      rdchk(0);
      @(negedge clk) result_ack = 1'b1;
      mdl_cnt = 0;
      @(negedge clk) result_ack = 1'b0;
      #1 check("ack_ready", result_ready, 1'b0);
      status("after_ack");

      // Frame 2: single pulse counts once, decode error mid-frame, read+write collision.
      for (int i = 0; i < 20; i++) wr(SADDR, 16'($urandom), $urandom_range(1, 5), 1'b0, 1'b0);
      wr(SADDR, 16'($urandom), 4, 1'b0, 1'b0);
      status("single_pulse");
      wr(64'h10, 16'h1234, 4, 1'b0, 1'b0);
      status("decode_err");
      wr(SADDR, 16'($urandom), 4, 1'b0, 1'b0);
      rdchk(mdl_cnt - 1);
      rdchk(0);
      wr(SADDR, 16'($urandom), 2, 1'b0, 1'b1);
      rdchk(mdl_cnt - 1);
      @(negedge clk) result_ack = 1'b1;
      @(negedge clk) result_ack = 1'b0;
      status("ack_ignored");
      while (mdl_cnt < N) begin
         if ($urandom_range(7) == 0) wr(bad_addr(), 16'($urandom), $urandom_range(1, 5), 1'b0, 1'b0);
         else                        wr(SADDR, 16'($urandom), $urandom_range(1, 5), 1'b0, 1'b0);
      end
      status("frame2");
      for (int i = 0; i < 6; i++) rdchk($urandom_range(N - 1));

      // Acknowledge coincident with a write edge: ack wins.
      wr(SADDR, 16'h5A5A, 1, 1'b1, 1'b0);
      check("ack_wr_ready", result_ready, 1'b0);
      status("ack_wr");

      // Reset mid-frame discards the partial frame.
      for (int i = 0; i < 100; i++) wr(SADDR, 16'($urandom), $urandom_range(1, 4), 1'b0, 1'b0);
      rdchk(99);
      @(negedge clk) n_rst = 1'b0;
      mdl_cnt = 0;
      #1 check("mid_rst_readdata", readdata, 16'h0);
      check("mid_rst_response", response, 2'b00);
      check("mid_rst_ready", result_ready, 1'b0);
      check("mid_rst_rd_data", rd_data, 16'h0);
      @(negedge clk) n_rst = 1'b1;
      status("post_rst");
      wr(SADDR, 16'($urandom), 3, 1'b0, 1'b0);
      rdchk(0);
      status("post_rst_wr");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
